// File: rtl/reg_file.sv
// reg_file: 32x8 register file; CLK/RST_N (sync, active-low), write DIN to [ADRX] on RF_WR, combinational reads DX_OUT=[ADRX], DY_OUT=[ADRY]
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic [ADDR_WIDTH-1:0] ADRX,
  input  logic [ADDR_WIDTH-1:0] ADRY,
  input  logic                  RF_WR,
  output logic [DATA_WIDTH-1:0] DX_OUT,
  output logic [DATA_WIDTH-1:0] DY_OUT
);
  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH] = '{default: '0};
  always_ff @(posedge CLK)
    if (!RST_N)
      for (int i = 0; i < 2**ADDR_WIDTH; i++) regs[i] <= '0;
    else if (RF_WR)
      regs[ADRX] <= DIN;
  assign DX_OUT = regs[ADRX];
  assign DY_OUT = regs[ADRY];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed-vector self-checking bench for reg_file
module tb_reg_file;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din = '0;
  logic [4:0] adrx = '0;
  logic [4:0] adry = '0;
  logic       rf_wr = 1'b0;
  logic [7:0] dx_out, dy_out;
  int vectors = 0;
  int miscompares = 0;

  reg_file dut (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .ADRX(adrx), .ADRY(adry),
    .RF_WR(rf_wr), .DX_OUT(dx_out), .DY_OUT(dy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    adrx = a;
    din = d;
    rf_wr = 1'b1;
    tick();
    rf_wr = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      adrx = 5'(i);
      adry = 5'(31 - i);
      #1;
      check({tag, "_dx"}, dx_out, 8'h00);
      check({tag, "_dy"}, dy_out, 8'h00);
    end
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_zero("post_reset");

    adrx = 5'd2;
    din = 8'd8;
    rf_wr = 1'b0;
    tick();
    check("no_wr_r2", dx_out, 8'h00);

    write(5'd2, 8'h08);
    #1;
    check("wr_r2_dx", dx_out, 8'h08);
    adry = 5'd2;
    #1;
    check("wr_r2_dy", dy_out, 8'h08);
    adry = 5'(8'hFF);
    #1;
    check("trunc_r31_dy", dy_out, 8'h00);

    for (int i = 0; i < 32; i++) write(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) begin
      adrx = 5'(i);
      adry = 5'((32 - i) % 32);
      #1;
      check("fill_dx", dx_out, 8'(i));
      check("fill_dy", dy_out, 8'((32 - i) % 32));
    end

    write(5'd5, 8'h11);
    adrx = 5'd5;
    din = 8'hAA;
    rf_wr = 1'b1;
    #1;
    check("nobypass_before", dx_out, 8'h11);
    din = 8'hAA;
    tick();
    rf_wr = 1'b0;
    din = 8'h3C;
    #1;
    check("nobypass_after", dx_out, 8'hAA);
    tick();
    check("wr_off_hold", dx_out, 8'hAA);

    write(5'd7, 8'h55);
    adrx = 5'd7;
    #1;
    check("r7_set", dx_out, 8'h55);
    rst_n = 1'b0;
    rf_wr = 1'b1;
    adrx = 5'd7;
    din = 8'h99;
    tick();
    rst_n = 1'b1;
    rf_wr = 1'b0;
    sweep_zero("rst_prio");

    write(5'd3, 8'h33);
    write(5'd4, 8'h44);
    adrx = 5'd3;
    adry = 5'd4;
    #1;
    check("indep_dy4", dy_out, 8'h44);
    check("indep_dx", dx_out, 8'h33);
    adry = 5'd3;
    #1;
    check("indep_dy3", dy_out, 8'h33);
    check("indep_dx", dx_out, 8'h33);
    adry = 5'd4;
    #1;
    check("indep_dy4b", dy_out, 8'h44);
    check("indep_dx", dx_out, 8'h33);

    write(5'd0, 8'hC3);
    adrx = 5'd0;
    adry = 5'd0;
    #1;
    check("r0_writable_dx", dx_out, 8'hC3);
    check("r0_writable_dy", dy_out, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
